// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: assembles USB packets (SYNC, PID, body, CRC, EOP) and
// hands them one byte at a time to the NRZI line transmitter via toggle
// handshakes. Bit stuffing and NRZI coding happen downstream.
//
// Handshake semantics:
//   tx byte path : a byte is outstanding while tx_wr != ack_s. A new byte is
//                  loaded into tx_byte only when nothing is outstanding and no
//                  load is pending; tx_wr is inverted on the following cycle.
//                  tx_byte is stable while a byte is outstanding.
//   tx eop path  : tx_eop is inverted once per packet after the last byte is
//                  acknowledged; the packet completes when eack_s == tx_eop.
//   payload path : a byte transfers on a cycle where dat_valid && dat_ready.
module usb_tx_packetizer #(
  parameter logic [7:0] SYNC_BYTE   = 8'h80,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pkt_start,
  input  logic [1:0] pkt_type,
  input  logic [3:0] pkt_pid,
  input  logic [6:0] tok_addr,
  input  logic [3:0] tok_endp,
  input  logic       pkt_zlp,
  input  logic       dat_valid,
  input  logic       dat_last,
  input  logic [7:0] dat_byte,
  output logic       dat_ready,
  output logic [7:0] tx_byte,
  output logic       tx_wr,
  input  logic       tx_wr_ack,
  output logic       tx_eop,
  input  logic       tx_eop_ack,
  output logic       busy,
  output logic       pkt_done,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOK1, S_TOK2,
    S_DATA, S_CRCL, S_CRCH, S_EOP, S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [SYNC_STAGES-1:0] eack_sync;
  logic                   ack_s;
  logic                   eack_s;
  logic                   pend;
  logic                   eop_sent;
  logic [1:0]             r_type;
  logic [3:0]             r_pid;
  logic [6:0]             r_addr;
  logic [3:0]             r_endp;
  logic                   r_zlp;
  logic [15:0]            crc16;
  logic [4:0]             crc5;
  logic [7:0]             tok2_byte;
  logic                   can_load;

  // CRC5 over {endp, addr}, bit 0 first (addr[0] .. endp[3]).
  function automatic logic [4:0] crc5_calc(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  // Reflected CRC-16/USB update with one byte, LSB first.
  function automatic logic [15:0] crc16_next(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign eack_s    = eack_sync[SYNC_STAGES-1];
  assign can_load  = !pend && (tx_wr == ack_s);
  assign dat_ready = (state == S_DATA) && can_load;
  assign dbg_state = state;
  assign crc5      = crc5_calc({r_endp, r_addr});
  // First CRC bit on the wire is ~crc5[4], which must sit at byte bit 3.
  assign tok2_byte = {~crc5[0], ~crc5[1], ~crc5[2], ~crc5[3], ~crc5[4], r_endp[3:1]};

  // Bring the asynchronous acknowledge toggles into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync  <= '0;
      eack_sync <= '0;
    end else begin
      ack_sync  <= {ack_sync[SYNC_STAGES-2:0], tx_wr_ack};
      eack_sync <= {eack_sync[SYNC_STAGES-2:0], tx_eop_ack};
    end
  end

  // Packet sequencer: loads bytes, toggles strobes, tracks CRCs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_byte  <= 8'h00;
      tx_wr    <= 1'b0;
      tx_eop   <= 1'b0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
      pend     <= 1'b0;
      eop_sent <= 1'b0;
      r_type   <= 2'd0;
      r_pid    <= 4'd0;
      r_addr   <= 7'd0;
      r_endp   <= 4'd0;
      r_zlp    <= 1'b0;
      crc16    <= 16'hFFFF;
    end else begin
      pkt_done <= 1'b0;
      // A byte loaded last cycle is strobed now.
      if (pend) begin
        tx_wr <= ~tx_wr;
        pend  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (pkt_start) begin
            r_type   <= pkt_type;
            r_pid    <= pkt_pid;
            r_addr   <= tok_addr;
            r_endp   <= tok_endp;
            r_zlp    <= pkt_zlp;
            crc16    <= 16'hFFFF;
            eop_sent <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (can_load) begin
            tx_byte <= SYNC_BYTE;
            pend    <= 1'b1;
            state   <= S_PID;
          end
        end
        S_PID: begin
          if (can_load) begin
            tx_byte <= {~r_pid, r_pid};
            pend    <= 1'b1;
            case (r_type)
              2'd1:    state <= S_TOK1;
              2'd2:    state <= r_zlp ? S_CRCL : S_DATA;
              default: state <= S_EOP;
            endcase
          end
        end
        S_TOK1: begin
          if (can_load) begin
            tx_byte <= {r_endp[0], r_addr};
            pend    <= 1'b1;
            state   <= S_TOK2;
          end
        end
        S_TOK2: begin
          if (can_load) begin
            tx_byte <= tok2_byte;
            pend    <= 1'b1;
            state   <= S_EOP;
          end
        end
        S_DATA: begin
          if (dat_valid && dat_ready) begin
            tx_byte <= dat_byte;
            pend    <= 1'b1;
            crc16   <= crc16_next(crc16, dat_byte);
            if (dat_last) state <= S_CRCL;
          end
        end
        S_CRCL: begin
          if (can_load) begin
            tx_byte <= ~crc16[7:0];
            pend    <= 1'b1;
            state   <= S_CRCH;
          end
        end
        S_CRCH: begin
          if (can_load) begin
            tx_byte <= ~crc16[15:8];
            pend    <= 1'b1;
            state   <= S_EOP;
          end
        end
        S_EOP: begin
          if (!eop_sent) begin
            if (can_load) begin
              tx_eop   <= ~tx_eop;
              eop_sent <= 1'b1;
            end
          end else if (eack_s == tx_eop) begin
            pkt_done <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Directed bench for usb_tx_packetizer with delayed toggle-acknowledge models.
module tb_usb_tx_packetizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_start;
  logic [1:0] pkt_type;
  logic [3:0] pkt_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       pkt_zlp;
  logic       dat_valid;
  logic       dat_last;
  logic [7:0] dat_byte;
  logic       dat_ready;
  logic [7:0] tx_byte;
  logic       tx_wr;
  logic       tx_wr_ack;
  logic       tx_eop;
  logic       tx_eop_ack;
  logic       busy;
  logic       pkt_done;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay[16];
  logic       prev_wr = 1'b0;
  logic [7:0] last_byte = 8'h00;
  int         ready_viol = 0;
  int         hold_viol = 0;
  int         eop_toggles = 0;
  int         wd_min = 3, wd_max = 3;
  int         wcnt = 0, wdelay = 3;
  int         ecnt = 0, dcnt = 0;
  logic       armed = 1'b0;

  usb_tx_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_start  (pkt_start),
    .pkt_type   (pkt_type),
    .pkt_pid    (pkt_pid),
    .tok_addr   (tok_addr),
    .tok_endp   (tok_endp),
    .pkt_zlp    (pkt_zlp),
    .dat_valid  (dat_valid),
    .dat_last   (dat_last),
    .dat_byte   (dat_byte),
    .dat_ready  (dat_ready),
    .tx_byte    (tx_byte),
    .tx_wr      (tx_wr),
    .tx_wr_ack  (tx_wr_ack),
    .tx_eop     (tx_eop),
    .tx_eop_ack (tx_eop_ack),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte scoreboard and handshake-rule monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_wr != prev_wr) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
      end
      if (dat_ready && (tx_wr != tx_wr_ack)) ready_viol++;
      if ((tx_wr != tx_wr_ack) && (tx_byte != last_byte)) hold_viol++;
    end
    prev_wr   = tx_wr;
    last_byte = tx_byte;
  end

  // Transmitter byte-ack model: returns tx_wr after a delay.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_wr_ack = 1'b0;
      wcnt      = 0;
    end else if (tx_wr != tx_wr_ack) begin
      if (wcnt >= wdelay) begin
        tx_wr_ack = tx_wr;
        wcnt      = 0;
        wdelay    = $urandom_range(wd_max, wd_min);
      end else begin
        wcnt++;
      end
    end
  end

  // Transmitter EOP-ack model; also times pkt_done against the returned toggle.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_eop_ack = 1'b0;
      ecnt       = 0;
      armed      = 1'b0;
    end else begin
      if (armed) begin
        dcnt++;
        if (pkt_done || dcnt > 10) begin
          check("done_latency", 32'(dcnt), 32'd3);
          armed = 1'b0;
        end
      end
      if (tx_eop != tx_eop_ack) begin
        if (ecnt >= 4) begin
          tx_eop_ack = tx_eop;
          ecnt       = 0;
          armed      = 1'b1;
          dcnt       = 0;
          eop_toggles++;
        end else begin
          ecnt++;
        end
      end
    end
  end

  task automatic start_pkt(input logic [1:0] t, input logic [3:0] pid,
                           input logic [6:0] a, input logic [3:0] e, input logic z);
    @(negedge clk);
    eop_toggles = 0;
    ready_viol  = 0;
    hold_viol   = 0;
    pkt_type  = t;
    pkt_pid   = pid;
    tok_addr  = a;
    tok_endp  = e;
    pkt_zlp   = z;
    pkt_start = 1'b1;
    @(negedge clk);
    pkt_start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
  endtask

  // Feed pay[0..n-1]; optionally mark the last one; pulse pkt_start after byte dup_at.
  task automatic send_bytes(input int n, input bit with_last, input int dup_at);
    int cnt;
    for (int i = 0; i < n; i++) begin
      dat_valid = 1'b1;
      dat_byte  = pay[i];
      dat_last  = with_last && (i == n - 1);
      cnt = 0;
      while (!dat_ready && cnt < 2000) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 2000) check("dat_ready_timeout", 32'(cnt), 32'd0);
      @(negedge clk);
      dat_valid = 1'b0;
      dat_last  = 1'b0;
      if (i == dup_at) begin
        pkt_start = 1'b1;
        pkt_type  = 2'd0;
        pkt_pid   = 4'b0010;
        @(negedge clk);
        pkt_start = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    while (!pkt_done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_done_seen"}, 32'(pkt_done), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(pkt_done), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_eop_toggles"}, 32'(eop_toggles), 32'd1);
    check({tag, "_ready_viol"}, 32'(ready_viol), 32'd0);
    check({tag, "_hold_viol"}, 32'(hold_viol), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
    check({tag, "_tx_wr"}, 32'(tx_wr), 32'd0);
    check({tag, "_tx_eop"}, 32'(tx_eop), 32'd0);
    check({tag, "_dat_ready"}, 32'(dat_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    pkt_start = 1'b0; pkt_type = 2'd0; pkt_pid = 4'd0; tok_addr = 7'd0;
    tok_endp = 4'd0; pkt_zlp = 1'b0; dat_valid = 1'b0; dat_last = 1'b0; dat_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ACK handshake
    exp_q = '{8'h80, 8'hD2};
    start_pkt(2'd0, 4'b0010, 7'd0, 4'd0, 1'b0);
    wait_done("ack");

    // 2: SETUP token addr 0 endp 0
    exp_q = '{8'h80, 8'h2D, 8'h00, 8'h10};
    start_pkt(2'd1, 4'b1101, 7'd0, 4'd0, 1'b0);
    wait_done("setup");

    // 3: DATA0 zero-length
    exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
    start_pkt(2'd2, 4'b0011, 7'd0, 4'd0, 1'b1);
    wait_done("zlp");

    // 4 + 5: DATA1 "123456789", random ack delay, stray pkt_start mid-stream
    wd_min = 3; wd_max = 40;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    exp_q = '{8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
              8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    start_pkt(2'd2, 4'b1011, 7'd0, 4'd0, 1'b0);
    send_bytes(9, 1'b1, 4);
    wait_done("data1");
    repeat (20) @(negedge clk);
    check("stray_start_ignored", 32'(busy), 32'd0);
    wd_min = 3; wd_max = 3;

    // Reserved type behaves as handshake
    exp_q = '{8'h80, 8'hD2};
    start_pkt(2'd3, 4'b0010, 7'd0, 4'd0, 1'b0);
    wait_done("rsvd");

    // 6: reset during DATA, then a clean ACK
    exp_q = '{8'h80, 8'h4B, 8'h31, 8'h32, 8'h33};
    start_pkt(2'd2, 4'b1011, 7'd0, 4'd0, 1'b0);
    send_bytes(3, 1'b0, -1);
    check("in_data_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{8'h80, 8'hD2};
    start_pkt(2'd0, 4'b0010, 7'd0, 4'd0, 1'b0);
    wait_done("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
